// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative RV64 M-extension execute unit (MUL, DIV, DIVU, REM,
// REMU). One shift-add or restoring-division iteration per clock. Divide by
// zero and signed overflow finish without iterating.
//
// Ports
//   clk       in   pipeline clock, rising edge
//   reset     in   synchronous active-high reset
//   flush     in   aborts any operation in flight, no done pulse
//   start     in   valid M-extension op presented this cycle
//   funct3    in   000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a      in   rs1 operand (multiplicand / dividend)
//   op_b      in   rs2 operand (multiplier / divisor)
//   rd        in   destination register
//   busy      out  high while iterating (stall request)
//   done      out  one-cycle pulse, result/result_rd valid
//   result    out  low product word, quotient or remainder
//   result_rd out  rd captured at start
// ---------------------------------------------------------------------------
module ex_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic [4:0]  result_rd
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e         state_q;
   logic [5:0]     cnt_q;
   logic [2:0]     funct3_q;
   logic [4:0]     rd_q;
   logic [63:0]    opA_q;
   logic [63:0]    opB_q;
   logic [127:0]   acc_q;
   logic           negQ_q;
   logic           negR_q;
   logic [63:0]    result_q;
   logic [4:0]     resultRd_q;

   logic [127:0]   acc_d;
   logic [64:0]    mulSum;
   logic [64:0]    remShift;
   logic           remGe;
   logic [63:0]    remDiff;
   logic [63:0]    quotFixed;
   logic [63:0]    remFixed;
   logic [63:0]    finalRes;
   logic           opValid;
   logic           isDiv;
   logic           isSigned;
   logic [63:0]    absA;
   logic [63:0]    absB;

   // Decode of the incoming op and operand magnitudes for signed division.
   always_comb begin
      opValid  = (funct3 == 3'b000) || funct3[2];
      isDiv    = funct3[2];
      isSigned = funct3[2] & ~funct3[0];
      absA     = (isSigned && op_a[63]) ? (~op_a + 64'd1) : op_a;
      absB     = (isSigned && op_b[63]) ? (~op_b + 64'd1) : op_b;
   end

   // One iteration of the datapath. For MUL the accumulator holds
   // {partial product, remaining multiplier bits}; each step adds the
   // multiplicand when the low bit is set and shifts right. For division it
   // holds {partial remainder, dividend/quotient}; each step shifts left one
   // bit and subtracts the divisor when it fits, shifting the quotient bit in.
   // The shifted remainder needs 65 bits because it can briefly exceed 2^64-1.
   always_comb begin
      mulSum   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opA_q} : 65'd0);
      remShift = {acc_q[127:64], acc_q[63]};
      remGe    = (remShift >= {1'b0, opB_q});
      remDiff  = remShift[63:0] - opB_q;
      if (funct3_q == 3'b000) begin
         acc_d = {mulSum, acc_q[63:1]};
      end else begin
         acc_d = {(remGe ? remDiff : remShift[63:0]), acc_q[62:0], remGe};
      end
      quotFixed = negQ_q ? (~acc_d[63:0] + 64'd1) : acc_d[63:0];
      remFixed  = negR_q ? (~acc_d[127:64] + 64'd1) : acc_d[127:64];
      if (funct3_q == 3'b000) begin
         finalRes = acc_d[63:0];
      end else if (funct3_q[1]) begin
         finalRes = remFixed;
      end else begin
         finalRes = quotFixed;
      end
   end

   // Control FSM with registered result. Reset beats flush, flush beats
   // start; corner cases (divide by zero, signed overflow) go straight to
   // DONE with their architecturally defined results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         funct3_q   <= 3'd0;
         rd_q       <= 5'd0;
         opA_q      <= 64'd0;
         opB_q      <= 64'd0;
         acc_q      <= 128'd0;
         negQ_q     <= 1'b0;
         negR_q     <= 1'b0;
         result_q   <= 64'd0;
         resultRd_q <= 5'd0;
      end else if (flush) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && opValid) begin
                  funct3_q <= funct3;
                  rd_q     <= rd;
                  cnt_q    <= 6'd0;
                  if (isDiv && (op_b == 64'd0)) begin
                     result_q   <= funct3[1] ? op_a : {64{1'b1}};
                     resultRd_q <= rd;
                     state_q    <= DONE;
                  end else if (isSigned && (op_a == {1'b1, 63'd0}) &&
                               (op_b == {64{1'b1}})) begin
                     result_q   <= funct3[1] ? 64'd0 : op_a;
                     resultRd_q <= rd;
                     state_q    <= DONE;
                  end else begin
                     opA_q   <= op_a;
                     opB_q   <= absB;
                     acc_q   <= isDiv ? {64'd0, absA} : {64'd0, op_b};
                     negQ_q  <= isSigned & (op_a[63] ^ op_b[63]);
                     negR_q  <= isSigned & op_a[63];
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd63) begin
                  result_q   <= finalRes;
                  resultRd_q <= rd_q;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q == CALC);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign result_rd = resultRd_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  branch/exception flush; aborts any operation in flight.
REQ-005 start  input  1  the ID/EX stage presents a valid M-extension op this cycle.
REQ-006 funct3  input  3  op select: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  64  rs1 operand (dividend or multiplicand).
REQ-008 op_b  input  64  rs2 operand (divisor or multiplier).
REQ-009 rd  input  5  destination register of the op.
REQ-010 busy  output  1  stall request to IF/ID and ID/EX; high while computing.
REQ-011 done  output  1  single-cycle pulse; result and result_rd are valid.
REQ-012 result  output  64  low 64 bits of the product, or the quotient or remainder.
REQ-013 result_rd  output  5  rd captured at start.

Function
REQ-014 The block SHALL implement the states IDLE, CALC and DONE:
- busy = (state == CALC).
- done = (state == DONE).
REQ-015 In IDLE, start=1 with an encoding listed in REQ-006 SHALL latch op_a, op_b, funct3 and rd.
REQ-016 The same start SHALL enter CALC with iteration counter = 0.
REQ-017 In IDLE, start=1 with any other funct3 (001, 010, 011) SHALL be ignored.
REQ-018 start SHALL be ignored in CALC and DONE.
REQ-019 MUL SHALL use 64 iterations of shift-add.
REQ-020 MUL result SHALL be bits [63:0] of the product; the sign does not matter for these bits.
REQ-021 DIV/REM SHALL divide operand magnitudes using 64 iterations of restoring division.
REQ-022 DIV sign fix: quotient negated when operand signs differ.
REQ-023 REM sign fix: remainder takes the sign of the dividend.
REQ-024 DIVU/REMU SHALL use the raw unsigned operands.
REQ-025 Latency (start sampled at edge 0):
- CALC performs one iteration at each of edges 1..64.
- Edge 64 enters DONE.
- done=1 for exactly the cycle after edge 64; busy=1 in the cycles after edges 0..63.
REQ-026 DONE SHALL return to IDLE on the next edge.
REQ-027 A start presented in that IDLE cycle SHALL be accepted.
REQ-028 Divide by zero (op_b = 0, any div/rem op) SHALL bypass CALC: edge 0 goes directly to DONE.
REQ-029 Divide by zero results: quotient = 0xFFFF_FFFF_FFFF_FFFF; remainder = op_a.
REQ-030 Signed overflow SHALL also bypass CALC: condition is DIV/REM with op_a = 0x8000_0000_0000_0000 and op_b = all ones.
REQ-031 Signed overflow results: quotient = op_a; remainder = 0.
REQ-032 flush=1 SHALL force IDLE on the next edge from any state, with no done pulse.
REQ-033 flush SHALL take priority over start in the same cycle.
REQ-034 result and result_rd SHALL hold their last done values until the next done.
REQ-035 Data SHALL be internally 128-bit (product, or remainder:quotient) and truncated on output.

Reset
REQ-036 reset=1 SHALL force IDLE, counter = 0, busy = 0, done = 0, result = 0 and result_rd = 0 on the next edge.
REQ-037 reset SHALL override flush and start.
REQ-038 reset in mid-CALC SHALL abort the operation with no done pulse.

Verification
REQ-039 MUL with op_a=7, op_b=0xFFFF_FFFF_FFFF_FFFD, rd=5 -> busy for 64 cycles, then done with result=0xFFFF_FFFF_FFFF_FFEB and result_rd=5.
REQ-040 Signed divide/remainder, each -> done after edge 64:
- DIV with op_a=-7, op_b=2 -> result=-3.
- REM with the same operands -> result=-1.
REQ-041 Divide by zero, each -> done in the cycle after edge 0 with busy never high:
- DIVU with op_a=0x1234, op_b=0 -> result=all ones.
- REMU with the same operands -> result=0x1234.
REQ-042 Signed overflow, each -> 1-cycle done:
- DIV with op_a=0x8000_0000_0000_0000, op_b=-1 -> result=0x8000_0000_0000_0000.
- REM with the same operands -> result=0.
REQ-043 flush pulsed at CALC iteration 30 -> busy=0 next cycle, no done.
- A following DIVU 100/7 is accepted -> result=14.
REQ-044 start pulsed during CALC with different operands -> ignored; the original op's result is unchanged.
